// File: rtl/addsub_pipe_acc_if.sv
// Operand/result handshake bundle for addsub_pipe_acc.
// The master side drives operands and accepts results; the slave side is the block.
interface addsub_pipe_acc_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             neg;
  logic             cout;
  logic [WIDTH-1:0] acc;

  modport master (
    output in_valid,
    output op,
    output a,
    output b,
    output acc_clr,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result,
    input  neg,
    input  cout,
    input  acc
  );

  modport slave (
    input  in_valid,
    input  op,
    input  a,
    input  b,
    input  acc_clr,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result,
    output neg,
    output cout,
    output acc
  );
endinterface

// File: rtl/addsub_pipe_acc.sv
// 2-stage pipelined unsigned add/sub with a running accumulator.
// Subtract results leave as magnitude plus a neg flag.
module addsub_pipe_acc #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  addsub_pipe_acc_if.slave bus
);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   SUB_CIN = {{WIDTH{1'b0}}, 1'b1};

  logic             w_adv;
  logic             w_fire;
  logic             w_sub;
  logic             w_acc_op;
  logic [WIDTH-1:0] w_acc_eff;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] w_y_op;
  logic [WIDTH:0]   w_cin;
  logic [WIDTH:0]   w_raw;
  logic             w_s2_neg;
  logic [WIDTH-1:0] w_s2_res;

  logic             r_s1_valid;
  logic [1:0]       r_s1_op;
  logic [WIDTH:0]   r_s1_raw;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_neg;
  logic             r_cout;
  logic [WIDTH-1:0] r_acc;

  assign w_adv        = !r_out_valid | bus.out_ready;
  assign bus.in_ready = w_adv & !rst;
  assign w_fire       = bus.in_valid & bus.in_ready;

  // op[0] selects subtract, op[1] selects the accumulator as X
  assign w_sub     = bus.op[0];
  assign w_acc_op  = bus.op[1];
  assign w_acc_eff = bus.acc_clr ? ACC_INIT : r_acc;
  assign w_x       = w_acc_op ? w_acc_eff : bus.a;
  assign w_y       = w_acc_op ? bus.a : bus.b;
  assign w_y_op    = w_sub ? ~w_y : w_y;
  assign w_cin     = w_sub ? SUB_CIN : '0;
  assign w_raw     = {1'b0, w_x} + {1'b0, w_y_op} + w_cin;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= ACC_INIT;
    end else if (w_fire && w_acc_op) begin
      r_acc <= w_raw[WIDTH-1:0];
    end else if (bus.acc_clr) begin
      r_acc <= ACC_INIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_raw   <= '0;
    end else if (w_adv) begin
      r_s1_valid <= w_fire;
      r_s1_op    <= bus.op;
      r_s1_raw   <= w_raw;
    end
  end

  // A borrow on plain A-B means B>A: return the two's-complement magnitude
  assign w_s2_neg = (r_s1_op == 2'b01) & !r_s1_raw[WIDTH];
  assign w_s2_res = w_s2_neg ? (~r_s1_raw[WIDTH-1:0] + ONE)
                             : r_s1_raw[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_neg       <= 1'b0;
      r_cout      <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= r_s1_valid;
      r_result    <= w_s2_res;
      r_neg       <= w_s2_neg;
      r_cout      <= r_s1_raw[WIDTH];
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.neg       = r_neg;
  assign bus.cout      = r_cout;
  assign bus.acc       = r_acc;
endmodule

// File: tb/tb_addsub_pipe_acc.sv
// Bench for addsub_pipe_acc: arithmetic reference model with a
// per-cycle compare process plus literal pins of directed cases.
module tb_addsub_pipe_acc;
  localparam int W = 8;
  localparam int M = 1 << W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  addsub_pipe_acc_if #(.WIDTH(W)) bus();

  addsub_pipe_acc #(.WIDTH(W), .ACC_INIT(8'd0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int r;
    int n;
    int c;
  } exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  exp_t log_q[$];
  int   m_acc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int op, input int x, input int y);
    exp_t e;
    int s;
    if ((op & 1) == 0) begin
      s   = x + y;
      e.r = s % M;
      e.c = (s >= M) ? 1 : 0;
      e.n = 0;
    end else begin
      e.c = (x >= y) ? 1 : 0;
      if (op == 1 && x < y) begin
        e.r = y - x;
        e.n = 1;
      end else begin
        e.r = (x - y + M) % M;
        e.n = 0;
      end
    end
    return e;
  endfunction

  // Per-cycle reference check; DUT settled at negedge, next edge commits
  logic       pv_stall = 1'b0;
  logic [7:0] p_res;
  logic       p_neg;
  logic       p_cout;
  always @(negedge clk) begin
    exp_t e;
    int   x;
    int   y;
    int   opi;
    chk("in_ready", int'(bus.in_ready),
        (!rst && (!bus.out_valid || bus.out_ready)) ? 1 : 0);
    chk("acc", int'(bus.acc), m_acc);
    if (pv_stall) begin
      chk("stall_valid", int'(bus.out_valid), 1);
      chk("stall_result", int'(bus.result), int'(p_res));
      chk("stall_neg", int'(bus.neg), int'(p_neg));
      chk("stall_cout", int'(bus.cout), int'(p_cout));
    end
    pv_stall = bus.out_valid && !bus.out_ready && !rst;
    p_res    = bus.result;
    p_neg    = bus.neg;
    p_cout   = bus.cout;
    if (rst) begin
      q.delete();
      m_acc = 0;
    end else begin
      if (bus.out_valid && q.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else if (bus.out_valid && bus.out_ready) begin
        e = q.pop_front();
        chk("result", int'(bus.result), e.r);
        chk("neg", int'(bus.neg), e.n);
        chk("cout", int'(bus.cout), e.c);
        e.r = int'(bus.result);
        e.n = int'(bus.neg);
        e.c = int'(bus.cout);
        log_q.push_back(e);
      end
      if (bus.in_valid && bus.in_ready) begin
        opi = int'(bus.op);
        if (opi >= 2) begin
          x = bus.acc_clr ? 0 : m_acc;
          y = int'(bus.a);
        end else begin
          x = int'(bus.a);
          y = int'(bus.b);
        end
        e = model(opi, x, y);
        q.push_back(e);
        if (opi >= 2) m_acc = e.r;
      end else if (bus.acc_clr) begin
        m_acc = 0;
      end
    end
  end

  // All tasks start and end at posedge+1
  task automatic send(input int op, input int a, input int b, input logic clr);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.op       = 2'(op);
    bus.a        = 8'(a);
    bus.b        = 8'(b);
    bus.acc_clr  = clr;
    @(negedge clk);
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.acc_clr  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    @(negedge clk);
    while ((q.size() != 0 || bus.out_valid) && t < 30) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0 || bus.out_valid) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_log(input int i, input int r, input int n, input int c);
    if (log_q.size() <= i) begin
      chk($sformatf("log%0d_missing", i), log_q.size(), i + 1);
    end else begin
      chk($sformatf("log%0d_result", i), log_q[i].r, r);
      chk($sformatf("log%0d_neg", i), log_q[i].n, n);
      chk($sformatf("log%0d_cout", i), log_q[i].c, c);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bus.in_valid  = 1'b0;
    bus.op        = 2'b00;
    bus.a         = '0;
    bus.b         = '0;
    bus.acc_clr   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_result", int'(bus.result), 0);
    chk("rst_neg", int'(bus.neg), 0);
    chk("rst_cout", int'(bus.cout), 0);
    chk("rst_acc", int'(bus.acc), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: wrapping add and latency
    bus.in_valid = 1'b1;
    bus.op = 2'b00;
    bus.a = 8'd200;
    bus.b = 8'd100;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!bus.out_valid && cnt < 10);
    chk("t1_latency", cnt, 2);
    chk("t1_result", int'(bus.result), 44);
    chk("t1_cout", int'(bus.cout), 1);
    chk("t1_neg", int'(bus.neg), 0);
    @(posedge clk);
    #1;
    drain();

    // 2: sign-magnitude subtract and equality boundary
    log_q.delete();
    send(1, 5, 9, 1'b0);
    send(1, 9, 9, 1'b0);
    send(1, 0, 255, 1'b0);
    send(0, 255, 1, 1'b0);
    drain();
    chk_log(0, 4, 1, 0);
    chk_log(1, 0, 0, 1);
    chk_log(2, 255, 1, 0);
    chk_log(3, 0, 0, 1);

    // 3: chained accumulator ops
    do_reset(1);
    log_q.delete();
    send(2, 10, 0, 1'b0);
    send(2, 20, 0, 1'b0);
    send(2, 30, 0, 1'b0);
    send(3, 70, 0, 1'b0);
    drain();
    chk_log(0, 10, 0, 0);
    chk_log(1, 30, 0, 0);
    chk_log(2, 60, 0, 0);
    chk_log(3, 246, 0, 0);
    chk("t3_acc", int'(bus.acc), 246);

    // 4: clear-then-operate, then clear alone
    do_reset(1);
    log_q.delete();
    send(2, 50, 0, 1'b0);
    chk("t4_acc50", int'(bus.acc), 50);
    send(2, 7, 0, 1'b1);
    chk("t4_acc7", int'(bus.acc), 7);
    drain();
    chk_log(1, 7, 0, 0);
    bus.acc_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.acc_clr = 1'b0;
    chk("t4_clr", int'(bus.acc), 0);

    // 5: back-pressure mid-stream
    log_q.delete();
    fork
      begin
        for (int i = 1; i <= 4; i++) send(0, i, i, 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("t5_stall_in_ready", int'(bus.in_ready), 0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("t5_count", log_q.size(), 4);
    for (int i = 0; i < 4; i++) chk_log(i, 2 * (i + 1), 0, 0);

    // 6: reset with beats in flight
    send(2, 5, 0, 1'b0);
    drain();
    bus.out_ready = 1'b0;
    send(0, 1, 2, 1'b0);
    send(0, 3, 4, 1'b0);
    log_q.delete();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.op = 2'b10;
    bus.a = 8'd99;
    @(negedge clk);
    chk("t6_in_ready_rst", int'(bus.in_ready), 0);
    @(negedge clk);
    chk("t6_out_valid", int'(bus.out_valid), 0);
    chk("t6_acc", int'(bus.acc), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("t6_no_stale", log_q.size(), 0);
    chk("t6_acc_end", int'(bus.acc), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
